// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline control: tracks in-flight destination tags from EX onward and
// derives ID stall, branch flush, EX forwarding selects and the data-memory freeze.
module pipeline_hazard_ctrl #(
  parameter int AW       = 4,
  parameter int DEPTH    = 3,
  parameter int MEM_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       forward_en,
  input  logic                       id_valid,
  input  logic [AW-1:0]              id_rn,
  input  logic [AW-1:0]              id_rm,
  input  logic                       id_use_rn,
  input  logic                       id_two_src,
  input  logic                       id_wb_en,
  input  logic [AW-1:0]              id_dest,
  input  logic                       id_mem_r,
  input  logic                       id_mem_acc,
  input  logic                       branch_taken,
  output logic                       hazard,
  output logic                       flush,
  output logic                       freeze_all,
  output logic [$clog2(DEPTH)-1:0]   sel_src1,
  output logic [$clog2(DEPTH)-1:0]   sel_src2,
  output logic                       dbg_state
);

  localparam int SW       = $clog2(DEPTH);
  localparam int CW       = $clog2(MEM_WAIT) + 1;
  localparam bit HAS_WAIT = (MEM_WAIT > 1);
  localparam logic [CW-1:0] CNT_INIT = HAS_WAIT ? CW'(MEM_WAIT - 2) : '0;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  // Per-stage tags. Load/access flags are only ever consulted in EX and MEM,
  // so they are kept for stages 0 and 1 only.
  logic [DEPTH-1:0] t_valid;
  logic [DEPTH-1:0] t_wb;
  logic [AW-1:0]    t_dest [DEPTH];
  logic [1:0]       t_mr;
  logic [1:0]       t_ma;
  logic [AW-1:0]    s0_src1, s0_src2;
  logic             s0_use1, s0_use2;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DEPTH-1:0] id_hit;
  logic             stall_any, load_use, pend, take_id;

  // ID source vs. in-flight destination comparison.
  always_comb begin
    id_hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      id_hit[k] = t_valid[k] & t_wb[k] &
                  ((id_use_rn  & (t_dest[k] == id_rn)) |
                   (id_two_src & (t_dest[k] == id_rm)));
    end
    stall_any = |id_hit[DEPTH-2:0];
    load_use  = id_hit[0] & t_mr[0];
    hazard    = id_valid & ~branch_taken & (forward_en ? load_use : stall_any);
  end

  assign flush = branch_taken & ~freeze_all;

  // Scan from the oldest stage down so the youngest matching producer wins.
  always_comb begin
    sel_src1 = '0;
    sel_src2 = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (t_valid[k] && t_wb[k] && !((k == 1) ? t_mr[1] : 1'b0)) begin
        if (s0_use1 && (t_dest[k] == s0_src1)) sel_src1 = SW'(k);
        if (s0_use2 && (t_dest[k] == s0_src2)) sel_src2 = SW'(k);
      end
    end
    if (!(forward_en && t_valid[0])) begin
      sel_src1 = '0;
      sel_src2 = '0;
    end
  end

  assign pend      = t_valid[1] & t_ma[1];
  assign dbg_state = state_q;

  // Memory-wait FSM: the release cycle is the cnt==0 visit of WAIT.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    freeze_all = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend && HAS_WAIT) begin
          freeze_all = 1'b1;
          state_d    = WAIT;
          cnt_d      = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          freeze_all = 1'b1;
          cnt_d      = cnt_q - CW'(1);
        end else begin
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign take_id = id_valid & ~flush & ~hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_valid <= '0;
      t_wb    <= '0;
      t_mr    <= '0;
      t_ma    <= '0;
      for (int k = 0; k < DEPTH; k++) t_dest[k] <= '0;
      s0_src1 <= '0;
      s0_src2 <= '0;
      s0_use1 <= 1'b0;
      s0_use2 <= 1'b0;
    end else if (!freeze_all) begin
      for (int k = 1; k < DEPTH; k++) begin
        t_valid[k] <= t_valid[k-1];
        t_wb[k]    <= t_wb[k-1];
        t_dest[k]  <= t_dest[k-1];
      end
      t_mr[1] <= t_mr[0];
      t_ma[1] <= t_ma[0];
      if (take_id) begin
        t_valid[0] <= 1'b1;
        t_wb[0]    <= id_wb_en;
        t_dest[0]  <= id_dest;
        t_mr[0]    <= id_mem_r;
        t_ma[0]    <= id_mem_acc;
        s0_src1    <= id_rn;
        s0_src2    <= id_rm;
        s0_use1    <= id_use_rn;
        s0_use2    <= id_two_src;
      end else begin
        t_valid[0] <= 1'b0;
        t_wb[0]    <= 1'b0;
        t_dest[0]  <= '0;
        t_mr[0]    <= 1'b0;
        t_ma[0]    <= 1'b0;
        s0_src1    <= '0;
        s0_src2    <= '0;
        s0_use1    <= 1'b0;
        s0_use2    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a driver pushes the hand-computed output
// vector {hazard, flush, freeze_all, sel_src1, sel_src2} per cycle; a monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 4;
  localparam int DEPTH = 3;
  localparam int MEM_WAIT = 4;
  localparam int W = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic forward_en = 1'b0, id_valid = 1'b0, id_use_rn = 1'b0, id_two_src = 1'b0;
  logic id_wb_en = 1'b0, id_mem_r = 1'b0, id_mem_acc = 1'b0, branch_taken = 1'b0;
  logic [AW-1:0] id_rn = '0, id_rm = '0, id_dest = '0;
  logic hazard, flush, freeze_all, dbg_state;
  logic [1:0] sel_src1, sel_src2;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rn;
    logic [AW-1:0] rm;
    logic          use_rn;
    logic          two_src;
    logic          wb_en;
    logic [AW-1:0] dest;
    logic          mem_r;
    logic          mem_acc;
  } instr_t;

  logic [W-1:0] exp_q[$];
  int           vec_q[$];
  int           checks = 0;
  int           errors = 0;
  int           vec_no = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.AW(AW), .DEPTH(DEPTH), .MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_r(id_mem_r), .id_mem_acc(id_mem_acc),
    .branch_taken(branch_taken), .hazard(hazard), .flush(flush), .freeze_all(freeze_all),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .dbg_state(dbg_state)
  );

  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic instr_t alu(input logic [AW-1:0] d, n, m);
    instr_t i = '0;
    i.valid = 1'b1; i.rn = n; i.rm = m; i.use_rn = 1'b1; i.two_src = 1'b1;
    i.wb_en = 1'b1; i.dest = d;
    return i;
  endfunction

  function automatic instr_t alu1(input logic [AW-1:0] d, n);
    instr_t i = '0;
    i.valid = 1'b1; i.rn = n; i.use_rn = 1'b1; i.wb_en = 1'b1; i.dest = d;
    return i;
  endfunction

  function automatic instr_t ldr(input logic [AW-1:0] d, b);
    instr_t i = '0;
    i.valid = 1'b1; i.rn = b; i.use_rn = 1'b1; i.wb_en = 1'b1; i.dest = d;
    i.mem_r = 1'b1; i.mem_acc = 1'b1;
    return i;
  endfunction

  function automatic instr_t str(input logic [AW-1:0] s, b);
    instr_t i = '0;
    i.valid = 1'b1; i.rn = b; i.rm = s; i.use_rn = 1'b1; i.two_src = 1'b1;
    i.mem_acc = 1'b1;
    return i;
  endfunction

  function automatic logic [W-1:0] ex(input logic h, f, z, input logic [1:0] s1, s2);
    return {h, f, z, s1, s2};
  endfunction

  localparam logic [W-1:0] Q = '0;

  // Inputs change #1 after the rising edge; outputs are judged on the falling edge.
  task automatic step(input instr_t i, input logic fwd, input logic bt, input logic r,
                      input logic [W-1:0] e);
    @(posedge clk);
    #1;
    rst = r; forward_en = fwd; branch_taken = bt;
    id_valid = i.valid; id_rn = i.rn; id_rm = i.rm; id_use_rn = i.use_rn;
    id_two_src = i.two_src; id_wb_en = i.wb_en; id_dest = i.dest;
    id_mem_r = i.mem_r; id_mem_acc = i.mem_acc;
    exp_q.push_back(e);
    vec_q.push_back(vec_no);
    vec_no++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, act;
      int n;
      e = exp_q.pop_front();
      n = vec_q.pop_front();
      act = {hazard, flush, freeze_all, sel_src1, sel_src2};
      checks++;
      if (act !== e)
        begin
          errors++;
          $display("FAIL vec%0d: got hazard=%b flush=%b freeze=%b sel1=%0d sel2=%0d, want hazard=%b flush=%b freeze=%b sel1=%0d sel2=%0d",
                   n, act[6], act[5], act[4], act[3:2], act[1:0], e[6], e[5], e[4], e[3:2], e[1:0]);
        end
    end
  end

  initial begin
    // Reset held, then idle after release.
    repeat (2) step(nop(), 1'b0, 1'b0, 1'b1, Q);
    repeat (3) step(nop(), 1'b1, 1'b0, 1'b0, Q);

    // Forwarding chain: ADD r1 ; SUB r2,r1,r3 ; ORR r4,r1,r2.
    step(alu(1, 2, 3), 1'b1, 1'b0, 1'b0, Q);
    step(alu(2, 1, 3), 1'b1, 1'b0, 1'b0, Q);
    step(alu(4, 1, 2), 1'b1, 1'b0, 1'b0, ex(0, 0, 0, 2'd1, 2'd0));
    step(nop(),        1'b1, 1'b0, 1'b0, ex(0, 0, 0, 2'd2, 2'd1));
    repeat (2) step(nop(), 1'b1, 1'b0, 1'b0, Q);

    // Load-use: LDR r5 ; ADD r6,r5,r5 (stall, then memory wait, then forward from WB).
    step(ldr(5, 0),    1'b1, 1'b0, 1'b0, Q);
    step(alu(6, 5, 5), 1'b1, 1'b0, 1'b0, ex(1, 0, 0, 2'd0, 2'd0));
    repeat (3) step(alu(6, 5, 5), 1'b1, 1'b0, 1'b0, ex(0, 0, 1, 2'd0, 2'd0));
    step(alu(6, 5, 5), 1'b1, 1'b0, 1'b0, Q);
    step(nop(),        1'b1, 1'b0, 1'b0, ex(0, 0, 0, 2'd2, 2'd2));
    repeat (2) step(nop(), 1'b1, 1'b0, 1'b0, Q);

    // Stall-only mode: ADD r1 ; SUB r2,r1,r3 stalls two cycles, no forwarding.
    step(alu(1, 2, 3), 1'b0, 1'b0, 1'b0, Q);
    repeat (2) step(alu(2, 1, 3), 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 2'd0, 2'd0));
    step(alu(2, 1, 3), 1'b0, 1'b0, 1'b0, Q);
    repeat (3) step(nop(), 1'b0, 1'b0, 1'b0, Q);

    // STR then LDR: 3 frozen cycles each, one open cycle between; branch during freeze.
    step(str(7, 0), 1'b1, 1'b0, 1'b0, Q);
    step(ldr(8, 0), 1'b1, 1'b0, 1'b0, Q);
    repeat (3) step(nop(), 1'b1, 1'b0, 1'b0, ex(0, 0, 1, 2'd0, 2'd0));
    step(nop(), 1'b1, 1'b0, 1'b0, Q);
    step(nop(), 1'b1, 1'b0, 1'b0, ex(0, 0, 1, 2'd0, 2'd0));
    step(nop(), 1'b1, 1'b1, 1'b0, ex(0, 0, 1, 2'd0, 2'd0));
    step(nop(), 1'b1, 1'b0, 1'b0, ex(0, 0, 1, 2'd0, 2'd0));
    repeat (3) step(nop(), 1'b1, 1'b0, 1'b0, Q);

    // Branch beats a pending stall; the flushed SUB r2 must not appear in EX.
    step(alu(1, 2, 3), 1'b0, 1'b0, 1'b0, Q);
    step(alu(2, 1, 3), 1'b0, 1'b1, 1'b0, ex(0, 1, 0, 2'd0, 2'd0));
    step(alu1(4, 2),   1'b0, 1'b0, 1'b0, Q);
    repeat (3) step(nop(), 1'b0, 1'b0, 1'b0, Q);

    // Reset in the middle of a memory wait drops the freeze at once.
    step(str(7, 0), 1'b1, 1'b0, 1'b0, Q);
    step(nop(),     1'b1, 1'b0, 1'b0, Q);
    step(nop(),     1'b1, 1'b0, 1'b0, ex(0, 0, 1, 2'd0, 2'd0));
    step(nop(),     1'b1, 1'b0, 1'b1, Q);
    repeat (3) step(nop(), 1'b1, 1'b0, 1'b0, Q);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
